// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty execute-stage controller.
// Holds the ALU select codes, instruction format codes, instruction field
// bit positions and the controller state encoding. No ports.
package bitty_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 8;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_SUB = 3'd1;
  localparam logic [2:0] SEL_AND = 3'd2;
  localparam logic [2:0] SEL_OR  = 3'd3;
  localparam logic [2:0] SEL_XOR = 3'd4;
  localparam logic [2:0] SEL_SHL = 3'd5;
  localparam logic [2:0] SEL_SHR = 3'd6;
  localparam logic [2:0] SEL_CMP = 3'd7;

  localparam logic [1:0] FMT_RR  = 2'b00;
  localparam logic [1:0] FMT_RI  = 2'b01;
  localparam logic [1:0] FMT_LI  = 2'b10;
  localparam logic [1:0] FMT_RSV = 2'b11;

  // The imm8 field overlaps ry; which one is meaningful depends on fmt.
  localparam int RX_MSB  = 15;
  localparam int RX_LSB  = 13;
  localparam int RY_MSB  = 12;
  localparam int RY_LSB  = 10;
  localparam int IMM_MSB = 12;
  localparam int IMM_LSB = 5;
  localparam int SEL_MSB = 4;
  localparam int SEL_LSB = 2;
  localparam int FMT_MSB = 1;
  localparam int FMT_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/bitty_regfile.sv
// Register file for the bitty execute stage: NREG registers of DATA_W bits.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset (clears all to 0)
//   we_i, waddr_i,      single synchronous write port
//   wdata_i
//   raddrA_i/rdataA_o   combinational read port for operand A
//   raddrB_i/rdataB_o   combinational read port for operand B
//   raddrDbg_i/         combinational debug read port
//   rdataDbg_o
module bitty_regfile
  import bitty_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int NREG   = NUM_REGS,
  parameter int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddrA_i,
  output logic [DATA_W-1:0] rdataA_o,
  input  logic [AW-1:0]     raddrB_i,
  output logic [DATA_W-1:0] rdataB_o,
  input  logic [AW-1:0]     raddrDbg_i,
  output logic [DATA_W-1:0] rdataDbg_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Storage: every register clears on reset; one write per clock when
  // enabled. A write becomes visible on the read ports the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports are plain muxes with no bypass from the write port.
  assign rdataA_o   = regs_q[raddrA_i];
  assign rdataB_o   = regs_q[raddrB_i];
  assign rdataDbg_o = regs_q[raddrDbg_i];

endmodule

// File: rtl/bitty_exec_ctrl.sv
// Execute-stage controller feeding a 16-bit combinational ALU.
// Accepts one instruction per valid/ready handshake, registers the ALU
// operands and select, then writes the ALU result (or the immediate, for
// load-immediate) back into the internal register file one cycle later.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   instr_valid/      instruction handshake; ready only in IDLE
//   instr_ready
//   instr             16-bit instruction word {rx, ry|imm8, sel, fmt}
//   alu_in_a/b        registered ALU operands
//   alu_select        registered ALU operation
//   alu_out           ALU result, consumed at writeback
//   done, illegal     one-cycle retire pulse / reserved-format flag
//   dbg_rsel/         combinational debug read of the register file
//   dbg_rdata
module bitty_exec_ctrl
  import bitty_pkg::*;
#(
  parameter int DATA_W = DATA_WIDTH,
  parameter int NREG   = NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [2:0]        alu_select,
  input  logic [DATA_W-1:0] alu_out,
  output logic              done,
  output logic              illegal,
  input  logic [2:0]        dbg_rsel,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_e            state_q;
  logic [2:0]        rx_q;
  logic [1:0]        fmt_q;
  logic [DATA_W-1:0] aluInA_q;
  logic [DATA_W-1:0] aluInB_q;
  logic [2:0]        aluSel_q;
  logic              done_q;
  logic              illegal_q;

  logic [2:0]        instrRx;
  logic [2:0]        instrRy;
  logic [7:0]        instrImm;
  logic [2:0]        instrSel;
  logic [1:0]        instrFmt;
  logic [DATA_W-1:0] immExt;
  logic [DATA_W-1:0] rdataA;
  logic [DATA_W-1:0] rdataB;
  logic              wrEn;
  logic [DATA_W-1:0] wrData;

  assign instrRx  = instr[RX_MSB:RX_LSB];
  assign instrRy  = instr[RY_MSB:RY_LSB];
  assign instrImm = instr[IMM_MSB:IMM_LSB];
  assign instrSel = instr[SEL_MSB:SEL_LSB];
  assign instrFmt = instr[FMT_MSB:FMT_LSB];
  assign immExt   = {{(DATA_W-8){1'b0}}, instrImm};

  // Writeback happens on the EXEC edge. For load-immediate the immediate is
  // already sitting in operand B, so no separate immediate latch is needed.
  assign wrEn   = (state_q == ST_EXEC) && (fmt_q != FMT_RSV);
  assign wrData = (fmt_q == FMT_LI) ? aluInB_q : alu_out;

  bitty_regfile #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (wrEn),
    .waddr_i    (rx_q),
    .wdata_i    (wrData),
    .raddrA_i   (instrRx),
    .rdataA_o   (rdataA),
    .raddrB_i   (instrRy),
    .rdataB_o   (rdataB),
    .raddrDbg_i (dbg_rsel),
    .rdataDbg_o (dbg_rdata)
  );

  // Two-state controller. IDLE captures operands on a handshake; EXEC
  // raises the retire pulse and always returns to IDLE. Operand registers
  // only load on a handshake so the ALU inputs stay quiet while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rx_q      <= '0;
      fmt_q     <= '0;
      aluInA_q  <= '0;
      aluInB_q  <= '0;
      aluSel_q  <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            rx_q     <= instrRx;
            fmt_q    <= instrFmt;
            aluInA_q <= rdataA;
            aluInB_q <= (instrFmt == FMT_RR) ? rdataB : immExt;
            aluSel_q <= instrSel;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          done_q    <= 1'b1;
          illegal_q <= (fmt_q == FMT_RSV);
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_in_a    = aluInA_q;
  assign alu_in_b    = aluInB_q;
  assign alu_select  = aluSel_q;
  assign done        = done_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_bitty_exec_ctrl.sv
// Testbench for bitty_exec_ctrl. Supplies a behavioural ALU on alu_out,
// keeps a register-array model of the architectural state, and drives
// directed vectors, a held-valid sequence, a mid-operation reset and a
// random instruction stream.
module tb_bitty_exec_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [2:0]  alu_select;
  logic [15:0] alu_out;
  logic        done;
  logic        illegal;
  logic [2:0]  dbg_rsel;
  logic [15:0] dbg_rdata;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [15:0] model [8];
  logic [15:0] lastA;
  logic [15:0] lastB;
  logic [2:0]  lastSel;

  typedef struct {
    logic [15:0] ins;
    logic [2:0]  chkReg;
    logic [15:0] expVal;
  } vec_t;

  vec_t vecs [21];

  bitty_exec_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_in_a    (alu_in_a),
    .alu_in_b    (alu_in_b),
    .alu_select  (alu_select),
    .alu_out     (alu_out),
    .done        (done),
    .illegal     (illegal),
    .dbg_rsel    (dbg_rsel),
    .dbg_rdata   (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: plain arithmetic on unsigned 16-bit values.
  function automatic logic [15:0] aluRef(input logic [2:0] sel, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    case (sel)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << (b % 16);
      3'd6: r = a >> (b % 16);
      default: r = (a > b) ? 16'd1 : ((a < b) ? 16'd2 : 16'd0);
    endcase
    return r;
  endfunction

  assign alu_out = aluRef(alu_select, alu_in_a, alu_in_b);

  function automatic logic [15:0] encRR(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] sel);
    return {rx, ry, 5'b00000, sel, 2'b00};
  endfunction

  function automatic logic [15:0] encImm(input logic [2:0] rx, input logic [7:0] imm, input logic [2:0] sel, input logic [1:0] fmt);
    return {rx, imm, sel, fmt};
  endfunction

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one instruction starting shortly after a negedge while IDLE.
  // Checks operand capture in EXEC, the retire pulse one cycle later and
  // the written register, and returns just after the done negedge so the
  // next call hands over at the earliest possible edge.
  task automatic applyStimulus(input logic [15:0] ins);
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [2:0]  sel;
    logic [1:0]  fmt;
    logic [15:0] imm;
    logic [15:0] expA;
    logic [15:0] expB;
    rx   = ins[15:13];
    ry   = ins[12:10];
    imm  = {8'h00, ins[12:5]};
    sel  = ins[4:2];
    fmt  = ins[1:0];
    expA = model[rx];
    expB = (fmt == 2'b00) ? model[ry] : imm;
    checkOutput("readyIdle", 16'(instr_ready), 16'd1);
    instr       = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    checkOutput("readyExec", 16'(instr_ready), 16'd0);
    checkOutput("doneExec", 16'(done), 16'd0);
    checkOutput("aluInA", alu_in_a, expA);
    checkOutput("aluInB", alu_in_b, expB);
    checkOutput("aluSelect", 16'(alu_select), 16'(sel));
    @(negedge clk);
    checkOutput("donePulse", 16'(done), 16'd1);
    checkOutput("illegalPulse", 16'(illegal), (fmt == 2'b11) ? 16'd1 : 16'd0);
    if (fmt == 2'b00 || fmt == 2'b01) begin
      model[rx] = aluRef(sel, expA, expB);
    end else if (fmt == 2'b10) begin
      model[rx] = imm;
    end
    lastA    = expA;
    lastB    = expB;
    lastSel  = sel;
    dbg_rsel = rx;
    #1;
    checkOutput("writeback", dbg_rdata, model[rx]);
  endtask

  task automatic resetModel();
    for (int i = 0; i < 8; i++) begin
      model[i] = 16'd0;
    end
    lastA   = 16'd0;
    lastB   = 16'd0;
    lastSel = 3'd0;
  endtask

  initial begin
    int doneCount;
    int gap;

    // Directed vectors with hand-computed register results.
    vecs[0]  = '{encImm(3'd3, 8'hA5, 3'd0, 2'b10), 3'd3, 16'h00A5};
    vecs[1]  = '{encImm(3'd1, 8'hFF, 3'd0, 2'b10), 3'd1, 16'h00FF};
    vecs[2]  = '{encImm(3'd1, 8'h08, 3'd5, 2'b01), 3'd1, 16'hFF00};
    vecs[3]  = '{encImm(3'd2, 8'h01, 3'd0, 2'b10), 3'd2, 16'h0001};
    vecs[4]  = '{encImm(3'd2, 8'h08, 3'd5, 2'b01), 3'd2, 16'h0100};
    vecs[5]  = '{encRR(3'd1, 3'd2, 3'd0),          3'd1, 16'h0000};
    vecs[6]  = '{encImm(3'd1, 8'hFF, 3'd0, 2'b01), 3'd1, 16'h00FF};
    vecs[7]  = '{encImm(3'd2, 8'hFF, 3'd0, 2'b10), 3'd2, 16'h00FF};
    vecs[8]  = '{encRR(3'd1, 3'd2, 3'd0),          3'd1, 16'h01FE};
    vecs[9]  = '{encImm(3'd4, 8'h05, 3'd0, 2'b10), 3'd4, 16'h0005};
    vecs[10] = '{encRR(3'd4, 3'd4, 3'd7),          3'd4, 16'h0000};
    vecs[11] = '{encImm(3'd4, 8'h03, 3'd0, 2'b10), 3'd4, 16'h0003};
    vecs[12] = '{encImm(3'd4, 8'h07, 3'd7, 2'b01), 3'd4, 16'h0002};
    vecs[13] = '{encImm(3'd7, 8'h01, 3'd1, 2'b01), 3'd7, 16'hFFFF};
    vecs[14] = '{encImm(3'd7, 8'h13, 3'd6, 2'b01), 3'd7, 16'h1FFF};
    vecs[15] = '{encImm(3'd3, 8'h3C, 3'd0, 2'b11), 3'd3, 16'h00A5};
    vecs[16] = '{encImm(3'd3, 8'hFF, 3'd4, 2'b01), 3'd3, 16'h005A};
    vecs[17] = '{encImm(3'd7, 8'h0F, 3'd2, 2'b01), 3'd7, 16'h000F};
    vecs[18] = '{encImm(3'd7, 8'hF0, 3'd3, 2'b01), 3'd7, 16'h00FF};
    vecs[19] = '{encRR(3'd0, 3'd3, 3'd1),          3'd0, 16'hFFA6};
    vecs[20] = '{encImm(3'd3, 8'h14, 3'd5, 2'b01), 3'd3, 16'h05A0};

    rst_n       = 1'b1;
    instr_valid = 1'b0;
    instr       = 16'd0;
    dbg_rsel    = 3'd0;
    resetModel();

    // Reset asserted mid-cycle, before the first rising edge.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rstReady", 16'(instr_ready), 16'd1);
    checkOutput("rstDone", 16'(done), 16'd0);
    checkOutput("rstIllegal", 16'(illegal), 16'd0);
    checkOutput("rstAluA", alu_in_a, 16'd0);
    checkOutput("rstAluB", alu_in_b, 16'd0);
    checkOutput("rstAluSel", 16'(alu_select), 16'd0);
    for (int r = 0; r < 8; r++) begin
      dbg_rsel = 3'(r);
      #0.1;
      checkOutput($sformatf("rstReg%0d", r), dbg_rdata, 16'd0);
    end
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].ins);
      dbg_rsel = vecs[i].chkReg;
      #1;
      checkOutput($sformatf("vec%0d", i), dbg_rdata, vecs[i].expVal);
    end

    // Held-valid stream of three dependent R5 += 1 instructions.
    instr       = encImm(3'd5, 8'h01, 3'd0, 2'b01);
    instr_valid = 1'b1;
    doneCount   = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("b2bReady%0d", k), 16'(instr_ready), (k % 2 == 0) ? 16'd1 : 16'd0);
      checkOutput($sformatf("b2bDone%0d", k), 16'(done), (k % 2 == 0) ? 16'd1 : 16'd0);
      if (k % 2 == 1) begin
        checkOutput($sformatf("b2bOperand%0d", k), alu_in_a, 16'((k - 1) / 2));
      end
      if (done) doneCount++;
    end
    instr_valid = 1'b0;
    model[5]    = model[5] + 16'd3;
    lastA       = 16'd2;
    lastB       = 16'd1;
    lastSel     = 3'd0;
    checkOutput("b2bDoneCount", 16'(doneCount), 16'd3);
    dbg_rsel = 3'd5;
    #1;
    checkOutput("b2bR5", dbg_rdata, 16'd3);

    // Reset pulsed while an R6 update is in EXEC: nothing may retire.
    #1;
    instr       = encImm(3'd6, 8'h09, 3'd0, 2'b01);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput("midRstExec", 16'(instr_ready), 16'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstReady", 16'(instr_ready), 16'd1);
    checkOutput("midRstAluA", alu_in_a, 16'd0);
    checkOutput("midRstAluB", alu_in_b, 16'd0);
    checkOutput("midRstSel", 16'(alu_select), 16'd0);
    @(negedge clk);
    checkOutput("midRstDone", 16'(done), 16'd0);
    checkOutput("midRstIllegal", 16'(illegal), 16'd0);
    #1 rst_n = 1'b1;
    resetModel();
    dbg_rsel = 3'd6;
    #1;
    checkOutput("midRstR6", dbg_rdata, 16'd0);
    @(negedge clk);
    checkOutput("postRstDone", 16'(done), 16'd0);
    #1;
    applyStimulus(encImm(3'd6, 8'h12, 3'd0, 2'b10));
    checkOutput("resumeR6", dbg_rdata, 16'h0012);

    // Random instructions with idle gaps; instr wiggles while valid is low.
    for (int n = 0; n < 80; n++) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        instr = 16'($urandom);
        @(negedge clk);
        checkOutput("idleDone", 16'(done), 16'd0);
        checkOutput("idleReady", 16'(instr_ready), 16'd1);
        checkOutput("idleAluA", alu_in_a, lastA);
        checkOutput("idleAluB", alu_in_b, lastB);
        checkOutput("idleSel", 16'(alu_select), 16'(lastSel));
        #1;
      end
      applyStimulus(16'($urandom));
    end

    for (int r = 0; r < 8; r++) begin
      dbg_rsel = 3'(r);
      #0.1;
      checkOutput($sformatf("finalReg%0d", r), dbg_rdata, model[r]);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
